// File: rtl/rv32_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32_fetch_pkg
// Purpose  : Shared fetch-path types and constants for the RV32 front end.
// Revision : 1.0
// ============================================================================
package rv32_fetch_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
   } fetch_entry_t;

   localparam logic [31:0] INSN_NOP = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/prefetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : prefetch_fifo
// Purpose  : Synchronous DEPTH-entry FIFO of fetch_entry_t with push/pop/flush.
// Revision : 1.0
// ============================================================================
module prefetch_fifo
   import rv32_fetch_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_push,
   input  logic                         i_pop,
   input  logic                         i_flush,
   input  fetch_entry_t                 i_data,
   output fetch_entry_t                 o_head,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   fetch_entry_t        r_mem [DEPTH];
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [CNT_W-1:0]    r_count;
   logic                w_full;
   logic                w_do_pop;
   logic                w_do_push;

   assign w_full    = (r_count == CNT_W'(DEPTH));
   assign w_do_pop  = i_pop && (r_count != '0);
   assign w_do_push = i_push && (!w_full || w_do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '{pc: 32'h0, insn: INSN_NOP};
         end
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_empty = (r_count == '0);

   // The issue-credit rule upstream must never let a response land in a full queue.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(i_push && !i_flush && w_full && !w_do_pop));

endmodule
`default_nettype wire

// File: rtl/rv32_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : rv32_prefetch_unit
// Purpose  : Pipelined imem fetch with DEPTH-entry prefetch queue and redirect.
//            Optional empty-queue bypass enabled by macro ROC_PF_BYPASS_EN.
// Revision : 1.0
// ============================================================================
module rv32_prefetch_unit
   import rv32_fetch_pkg::*;
#(
   parameter int          ADDR_WIDTH_I = 10,
   parameter int          DATA_WIDTH_I = 32,
   parameter int          DEPTH        = 4,
   parameter logic [31:0] RESET_PC     = 32'h0000_0000
)(
   input  logic                    clk,
   input  logic                    rst_n,
   output logic                    imem_en,
   output logic [ADDR_WIDTH_I-1:0] imem_addr,
   input  logic [DATA_WIDTH_I-1:0] data_imem,
   input  logic                    redirect_valid,
   input  logic [31:0]             redirect_pc,
   output logic                    instr_valid,
   output logic [31:0]             instr,
   output logic [31:0]             instr_pc,
   input  logic                    instr_ready
);

   localparam int CNT_W = $clog2(DEPTH+1);

   logic [31:0]      r_fetch_pc;
   logic [31:0]      r_resp_pc;
   logic             r_inflight;
   logic             r_kill;

   logic [31:0]      w_redir_pc;
   logic             w_credit;
   logic             w_resp_live;
   logic             w_push;
   logic             w_pop;
   logic             w_empty;
   logic [CNT_W-1:0] w_count;
   fetch_entry_t     w_resp;
   fetch_entry_t     w_head;

   assign w_redir_pc  = redirect_pc & 32'hFFFF_FFFC;
   // Occupancy plus the outstanding read must leave room for the response.
   assign w_credit    = (int'(w_count) + int'(r_inflight)) < DEPTH;
   assign imem_en     = rst_n && !redirect_valid && w_credit;
   assign imem_addr   = r_fetch_pc[ADDR_WIDTH_I+1:2];
   assign w_resp_live = r_inflight && !r_kill && !redirect_valid;
   assign w_resp      = '{pc: r_resp_pc, insn: data_imem};
   assign w_pop       = instr_ready && !w_empty && !redirect_valid;

`ifdef ROC_PF_BYPASS_EN
   logic w_bypass;
   assign w_bypass    = w_resp_live && w_empty;
   assign w_push      = w_resp_live && !(w_bypass && instr_ready);
   assign instr_valid = !w_empty || w_bypass;
   assign instr       = w_bypass ? data_imem : w_head.insn;
   assign instr_pc    = w_bypass ? r_resp_pc : w_head.pc;
`else
   assign w_push      = w_resp_live;
   assign instr_valid = !w_empty;
   assign instr       = w_head.insn;
   assign instr_pc    = w_head.pc;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc <= RESET_PC;
         r_resp_pc  <= '0;
         r_inflight <= 1'b0;
         r_kill     <= 1'b0;
      end else if (redirect_valid) begin
         r_fetch_pc <= w_redir_pc;
         r_inflight <= 1'b0;
         r_kill     <= r_inflight;
      end else begin
         r_inflight <= imem_en;
         r_kill     <= 1'b0;
         if (imem_en) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
            r_resp_pc  <= r_fetch_pc;
         end
      end
   end

   prefetch_fifo #(
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (redirect_valid),
      .i_data  (w_resp),
      .o_head  (w_head),
      .o_count (w_count),
      .o_empty (w_empty)
   );

endmodule
`default_nettype wire

// File: tb/tb_rv32_prefetch_unit.sv
`default_nettype none
// Testbench for rv32_prefetch_unit: directed vector table, hand sequences and
// randomized traffic checked against an in-order fetch stream model.
module tb_rv32_prefetch_unit;

   localparam int          AW    = 10;
   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0000_1000;
`ifdef ROC_PF_BYPASS_EN
   localparam int          LAT   = 1;
`else
   localparam int          LAT   = 2;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          imem_en;
   logic [AW-1:0] imem_addr;
   logic [31:0]   data_imem = '0;
   logic          redirect_valid = 1'b0;
   logic [31:0]   redirect_pc = '0;
   logic          instr_valid;
   logic [31:0]   instr;
   logic [31:0]   instr_pc;
   logic          instr_ready = 1'b0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        ready;
      logic        redir;
      logic [31:0] rpc;
      logic        ce;
      logic        en;
      logic [31:0] ipc;
      logic        cv;
      logic        v;
      logic [31:0] pc;
   } vec_t;

   vec_t tbl[$];

   rv32_prefetch_unit #(
      .ADDR_WIDTH_I (AW),
      .DATA_WIDTH_I (32),
      .DEPTH        (DEPTH),
      .RESET_PC     (RPC)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_en        (imem_en),
      .imem_addr      (imem_addr),
      .data_imem      (data_imem),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memword(input logic [AW-1:0] a);
      return {16'hC0DE, 6'h00, a};
   endfunction

   function automatic logic [AW-1:0] waddr(input logic [31:0] pc);
      return pc[AW+1:2];
   endfunction

   // Synchronous instruction memory: data valid the cycle after the request.
   always @(posedge clk) begin
      if (imem_en) data_imem <= memword(imem_addr);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic rd, input logic rr, input logic [31:0] rp,
                      input logic ce, input logic en, input logic [31:0] ipc,
                      input logic cv, input logic v, input logic [31:0] pc);
      vec_t e;
      e.ready = rd; e.redir = rr; e.rpc = rp;
      e.ce = ce; e.en = en; e.ipc = ipc;
      e.cv = cv; e.v = v; e.pc = pc;
      tbl.push_back(e);
   endtask

   task automatic drive(input logic rd, input logic rr, input logic [31:0] rp);
      instr_ready    = rd;
      redirect_valid = rr;
      redirect_pc    = rp;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int          since;
      int          outstanding;
      logic [31:0] exp_issue;
      logic [31:0] exp_pop;

      // Stream from reset, one per cycle.
      for (int c = 0; c < 8; c++)
         add(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, RPC + 32'(4*c),
             1'b1, (c >= LAT), RPC + 32'(4*(c-LAT)));
      // Redirect, then stall 10 cycles: only DEPTH requests may issue.
      add(1'b0, 1'b1, 32'h0000_0203, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      for (int k = 1; k <= 10; k++)
         add(1'b0, 1'b0, 32'h0, 1'b1, (k <= 4), 32'h200 + 32'(4*(k-1)),
             1'b1, (k >= LAT+1), 32'h200);
      // Release: queued entries drain back-to-back, stream resumes.
      for (int j = 0; j < 8; j++)
         add(1'b1, 1'b0, 32'h0, 1'b1, (j >= 1), 32'h210 + 32'(4*(j-1)),
             1'b1, 1'b1, 32'h200 + 32'(4*j));
      // Redirect together with ready, landing near the imem address wrap.
      add(1'b1, 1'b1, 32'h0000_0FF8, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      for (int k = 1; k <= 6; k++)
         add(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFF8 + 32'(4*(k-1)),
             1'b1, (k >= LAT+1), 32'hFF8 + 32'(4*(k-LAT-1)));

      repeat (3) @(negedge clk);
      #1;
      check("rst_imem_en", 32'(imem_en), 32'h0);
      check("rst_imem_addr", 32'(imem_addr), 32'(waddr(RPC)));
      check("rst_instr_valid", 32'(instr_valid), 32'h0);
      check("rst_instr", instr, 32'h0);
      check("rst_instr_pc", instr_pc, 32'h0);

      foreach (tbl[i]) begin
         @(negedge clk);
         rst_n = 1'b1;
         drive(tbl[i].ready, tbl[i].redir, tbl[i].rpc);
         #1;
         if (tbl[i].ce) begin
            check($sformatf("vec%0d_imem_en", i), 32'(imem_en), 32'(tbl[i].en));
            if (tbl[i].en)
               check($sformatf("vec%0d_imem_addr", i), 32'(imem_addr), 32'(waddr(tbl[i].ipc)));
         end
         if (tbl[i].cv) begin
            check($sformatf("vec%0d_instr_valid", i), 32'(instr_valid), 32'(tbl[i].v));
            if (tbl[i].v) begin
               check($sformatf("vec%0d_instr_pc", i), instr_pc, tbl[i].pc);
               check($sformatf("vec%0d_instr", i), instr, memword(waddr(tbl[i].pc)));
            end
         end
      end

      // Build 3 queued entries plus one read in flight, then redirect.
      @(negedge clk); drive(1'b0, 1'b1, 32'h0000_0100);
      repeat (5) begin
         @(negedge clk); drive(1'b0, 1'b0, 32'h0);
      end
      #1;
      check("kill_pre_valid", 32'(instr_valid), 32'h1);
      check("kill_pre_pc", instr_pc, 32'h100);
      @(negedge clk); drive(1'b1, 1'b1, 32'h0000_0203);
      for (int k = 1; k <= LAT+2; k++) begin
         @(negedge clk); drive(1'b1, 1'b0, 32'h0);
         #1;
         if (k <= LAT) begin
            check($sformatf("kill_r%0d_valid", k), 32'(instr_valid), 32'h0);
         end else begin
            check($sformatf("kill_r%0d_valid", k), 32'(instr_valid), 32'h1);
            check($sformatf("kill_r%0d_pc", k), instr_pc, 32'h200 + 32'(4*(k-LAT-1)));
            check($sformatf("kill_r%0d_instr", k), instr, memword(waddr(32'h200 + 32'(4*(k-LAT-1)))));
         end
      end

      // Asynchronous reset mid-stream.
      repeat (3) begin
         @(negedge clk); drive(1'b1, 1'b0, 32'h0);
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mrst_imem_en", 32'(imem_en), 32'h0);
      check("mrst_instr_valid", 32'(instr_valid), 32'h0);
      check("mrst_instr", instr, 32'h0);
      check("mrst_instr_pc", instr_pc, 32'h0);
      check("mrst_imem_addr", 32'(imem_addr), 32'(waddr(RPC)));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 32'h0);
      #1;
      check("mrst_c0_imem_en", 32'(imem_en), 32'h1);
      check("mrst_c0_imem_addr", 32'(imem_addr), 32'(waddr(RPC)));
      for (int c = 1; c <= LAT+1; c++) begin
         @(negedge clk);
         #1;
         if (c < LAT) begin
            check($sformatf("mrst_c%0d_valid", c), 32'(instr_valid), 32'h0);
         end else begin
            check($sformatf("mrst_c%0d_valid", c), 32'(instr_valid), 32'h1);
            check($sformatf("mrst_c%0d_pc", c), instr_pc, RPC + 32'(4*(c-LAT)));
         end
      end

      // Randomized traffic against an in-order stream model.
      since       = 0;
      outstanding = 0;
      exp_issue   = '0;
      exp_pop     = '0;
      for (int n = 0; n < 1500; n++) begin
         @(negedge clk);
         drive(($urandom_range(0, 9) < 7), (n == 0) || ($urandom_range(0, 39) == 0),
               ($urandom_range(0, 3) == 0) ? (32'h0000_0FF0 + 32'($urandom_range(0, 15))) : $urandom);
         #1;
         if (redirect_valid) begin
            check("rnd_redirect_en", 32'(imem_en), 32'h0);
            exp_issue   = redirect_pc & 32'hFFFF_FFFC;
            exp_pop     = exp_issue;
            outstanding = 0;
            since       = 0;
         end else begin
            since++;
            check("rnd_imem_en", 32'(imem_en), 32'(outstanding < DEPTH));
            if (since <= LAT)
               check("rnd_valid_low", 32'(instr_valid), 32'h0);
            else if (since == LAT+1)
               check("rnd_valid_rise", 32'(instr_valid), 32'h1);
            if (imem_en) begin
               check("rnd_imem_addr", 32'(imem_addr), 32'(waddr(exp_issue)));
               exp_issue = exp_issue + 32'd4;
               outstanding++;
            end
            if (instr_valid && instr_ready) begin
               check("rnd_instr_pc", instr_pc, exp_pop);
               check("rnd_instr", instr, memword(waddr(exp_pop)));
               exp_pop = exp_pop + 32'd4;
               outstanding--;
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
